// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin CDB grant, one-cycle-later result capture and registered broadcast.
// Branch flush drops grants, pending ownership and the beat in flight.
module cdb_arbiter #(
    parameter int N_REQ  = 4,
    parameter int TAG_W  = 8,
    parameter int DATA_W = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_br,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ-1:0]          i_in_valid,
    input  logic [N_REQ*TAG_W-1:0]    i_in_index,
    input  logic [N_REQ*DATA_W-1:0]   i_in_result,
    output logic [N_REQ-1:0]          o_grnt,
    output logic                      o_cdb_valid,
    output logic [TAG_W-1:0]          o_cdb_index,
    output logic [DATA_W-1:0]         o_cdb_result,
    output logic                      o_proto_err
);
    localparam int PW = $clog2(N_REQ);

    logic [N_REQ-1:0]  r_grnt;
    logic [PW-1:0]     r_gidx;
    logic [PW-1:0]     r_ptr;
    logic              r_pend_valid;
    logic [PW-1:0]     r_pend_owner;
    logic              r_flush;
    logic              r_cdb_valid;
    logic [TAG_W-1:0]  r_cdb_index;
    logic [DATA_W-1:0] r_cdb_result;
    logic              r_err;

    logic              w_found;
    logic [PW-1:0]     w_idx;
    logic [PW-1:0]     w_sel;
    logic [PW-1:0]     w_nxt;
    logic [N_REQ-1:0]  w_own;
    logic              w_bad;
    logic [TAG_W-1:0]  w_tag;
    logic [DATA_W-1:0] w_res;
    logic              w_hit;

    // First requester at or after the pointer, wrapping modulo N_REQ
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_ptr;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = PW'((int'(r_ptr) + k) % N_REQ);
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    assign w_nxt = PW'((int'(w_sel) + 1) % N_REQ);
    assign w_own = r_pend_valid ? (N_REQ'(1) << r_pend_owner) : '0;
    assign w_bad = |(i_in_valid & ~w_own);
    assign w_tag = i_in_index[r_pend_owner*TAG_W +: TAG_W];
    assign w_res = i_in_result[r_pend_owner*DATA_W +: DATA_W];
    // Tag 0 means "no tag", so such a result is never broadcast
    assign w_hit = r_pend_valid && i_in_valid[r_pend_owner] && (w_tag != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grnt       <= '0;
            r_gidx       <= '0;
            r_ptr        <= '0;
            r_pend_valid <= 1'b0;
            r_pend_owner <= '0;
            r_flush      <= 1'b0;
            r_cdb_valid  <= 1'b0;
            r_cdb_index  <= '0;
            r_cdb_result <= '0;
            r_err        <= 1'b0;
        end else begin
            // Results from units whose grant was flushed arrive one cycle later and are not errors
            if (w_bad && !r_flush)
                r_err <= 1'b1;
            r_flush <= i_br;
            if (i_br) begin
                r_grnt       <= '0;
                r_ptr        <= '0;
                r_pend_valid <= 1'b0;
                r_cdb_valid  <= 1'b0;
                r_cdb_index  <= '0;
                r_cdb_result <= '0;
            end else begin
                r_grnt       <= w_found ? (N_REQ'(1) << w_sel) : '0;
                r_gidx       <= w_sel;
                r_ptr        <= w_found ? w_nxt : r_ptr;
                r_pend_valid <= |r_grnt;
                r_pend_owner <= r_gidx;
                r_cdb_valid  <= w_hit;
                r_cdb_index  <= w_hit ? w_tag : '0;
                r_cdb_result <= w_hit ? w_res : '0;
            end
        end
    end

    assign o_grnt       = r_grnt;
    assign o_cdb_valid  = r_cdb_valid;
    assign o_cdb_index  = r_cdb_index;
    assign o_cdb_result = r_cdb_result;
    assign o_proto_err  = r_err;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed plus randomized checks of cdb_arbiter against a transaction-level model.
module tb_cdb_arbiter;
    localparam int N  = 4;
    localparam int TW = 8;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            br = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    inv = '0;
    logic [N*TW-1:0] idx = '0;
    logic [N*DW-1:0] res = '0;
    logic [N-1:0]    o_grnt;
    logic            o_cdb_valid;
    logic [TW-1:0]   o_cdb_index;
    logic [DW-1:0]   o_cdb_result;
    logic            o_proto_err;

    cdb_arbiter #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_br(br), .i_req(req),
        .i_in_valid(inv), .i_in_index(idx), .i_in_result(res),
        .o_grnt(o_grnt), .o_cdb_valid(o_cdb_valid), .o_cdb_index(o_cdb_index),
        .o_cdb_result(o_cdb_result), .o_proto_err(o_proto_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: owner of current grant, owner whose result is due, unit that will drive next (-1 = none)
    int            m_ptr, m_grant, m_pend, m_drive;
    bit            m_flush, m_err, m_cv;
    logic [TW-1:0] m_ci;
    logic [DW-1:0] m_cr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_ptr = 0; m_grant = -1; m_pend = -1; m_drive = -1;
        m_flush = 0; m_err = 0; m_cv = 0; m_ci = '0; m_cr = '0;
    endtask

    task automatic check_all();
        chk("grnt", 64'(o_grnt), (m_grant < 0) ? 64'd0 : (64'd1 << m_grant));
        chk("cdb_valid", 64'(o_cdb_valid), 64'(m_cv));
        chk("cdb_index", 64'(o_cdb_index), 64'(m_ci));
        chk("cdb_result", 64'(o_cdb_result), 64'(m_cr));
        chk("proto_err", 64'(o_proto_err), 64'(m_err));
    endtask

    task automatic tick();
        bit spur;
        @(posedge clk);
        spur = 0;
        for (int j = 0; j < N; j++)
            if (inv[j] && j != m_pend) spur = 1;
        if (spur && !m_flush) m_err = 1;
        m_drive = m_grant;
        if (br) begin
            m_grant = -1; m_pend = -1; m_ptr = 0; m_flush = 1;
            m_cv = 0; m_ci = '0; m_cr = '0;
        end else begin
            if (m_pend >= 0 && inv[m_pend] && idx[m_pend*TW +: TW] != '0) begin
                m_cv = 1; m_ci = idx[m_pend*TW +: TW]; m_cr = res[m_pend*DW +: DW];
            end else begin
                m_cv = 0; m_ci = '0; m_cr = '0;
            end
            m_pend = m_grant;
            m_grant = -1;
            for (int k = 0; k < N; k++)
                if (m_grant < 0 && req[(m_ptr + k) % N]) m_grant = (m_ptr + k) % N;
            if (m_grant >= 0) m_ptr = (m_grant + 1) % N;
            m_flush = 0;
        end
        @(negedge clk);
        check_all();
    endtask

    // Act as the functional units: the unit granted last cycle returns a tagged result
    task automatic drive(input bit en);
        inv = '0;
        idx = {$urandom, $urandom} >> (64 - N*TW);
        res = {$urandom, $urandom, $urandom, $urandom};
        if (en && m_drive >= 0) begin
            inv[m_drive] = 1'b1;
            idx[m_drive*TW +: TW] = TW'($urandom_range(1, 255));
        end
    endtask

    initial begin
        m_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester
        req = 4'b0100; drive(0); tick();
        chk("single_grnt", 64'(o_grnt), 64'h4);
        req = '0; tick();
        inv = 4'b0100; idx[2*TW +: TW] = 8'h15; res[2*DW +: DW] = 32'hDEADBEEF; tick();
        chk("single_valid", 64'(o_cdb_valid), 64'd1);
        chk("single_index", 64'(o_cdb_index), 64'h15);
        chk("single_result", 64'(o_cdb_result), 64'hDEADBEEF);
        inv = '0; tick();
        chk("single_pulse", 64'(o_cdb_valid), 64'd0);

        // Round-robin fairness from a reset pointer
        br = 1'b1; tick(); br = 1'b0;
        for (int k = 0; k < 8; k++) begin
            req = 4'hF; drive(1); tick();
            chk("rr_grnt", 64'(o_grnt), 64'd1 << (k % 4));
            if (k >= 2) chk("rr_beat", 64'(o_cdb_valid), 64'd1);
        end
        for (int k = 0; k < 2; k++) begin
            req = '0; drive(1); tick();
            chk("rr_drain_beat", 64'(o_cdb_valid), 64'd1);
        end

        // Pointer wrap
        req = 4'b0100; drive(1); tick();
        chk("wrap_g2", 64'(o_grnt), 64'h4);
        req = 4'b0011; drive(1); tick();
        chk("wrap_g0", 64'(o_grnt), 64'h1);
        drive(1); tick();
        chk("wrap_g1", 64'(o_grnt), 64'h2);
        req = '0; drive(1); tick(); drive(1); tick();

        // Flush on the capture edge
        req = 4'b0010; drive(1); tick();
        chk("flush_grant", 64'(o_grnt), 64'h2);
        req = '0; drive(0); tick();
        drive(1); br = 1'b1; tick();
        chk("flush_nobeat", 64'(o_cdb_valid), 64'd0);
        chk("flush_grnt0", 64'(o_grnt), 64'd0);
        br = 1'b0; req = 4'b1110; inv = '0; tick();
        chk("flush_ptr0", 64'(o_grnt), 64'h2);
        req = '0; drive(1); tick(); drive(1); tick();

        // Randomized traffic with flushes, no-shows and zero tags
        for (int c = 0; c < 400; c++) begin
            req = N'($urandom);
            br = ($urandom_range(15) == 0);
            drive($urandom_range(7) != 0);
            if (m_drive >= 0 && $urandom_range(7) == 0) idx[m_drive*TW +: TW] = '0;
            tick();
        end
        br = 1'b0; req = '0; drive(1); tick(); drive(1); tick();
        chk("rand_no_err", 64'(o_proto_err), 64'd0);

        // Protocol error is sticky and produces no beat
        inv = 4'b1000; idx[3*TW +: TW] = 8'h33; tick();
        chk("perr_set", 64'(o_proto_err), 64'd1);
        chk("perr_nobeat", 64'(o_cdb_valid), 64'd0);
        inv = '0; tick();
        chk("perr_sticky", 64'(o_proto_err), 64'd1);

        // No-show by the granted unit
        req = 4'b0001; tick();
        chk("noshow_grant", 64'(o_grnt), 64'h1);
        req = '0; tick(); tick();
        chk("noshow_nobeat", 64'(o_cdb_valid), 64'd0);
        req = 4'b0010; tick();
        chk("noshow_next", 64'(o_grnt), 64'h2);

        // Asynchronous reset while a beat is on the bus
        req = '0; drive(1); tick();
        drive(1); tick();
        chk("areset_pre", 64'(o_cdb_valid), 64'd1);
        inv = '0;
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        chk("areset_valid", 64'(o_cdb_valid), 64'd0);
        chk("areset_index", 64'(o_cdb_index), 64'd0);
        chk("areset_result", 64'(o_cdb_result), 64'd0);
        chk("areset_err", 64'(o_proto_err), 64'd0);
        chk("areset_grnt", 64'(o_grnt), 64'd0);
        req = 4'hF;
        @(posedge clk); #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_reset_grant", 64'(o_grnt), 64'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter and broadcast register sitting directly downstream of the reservation-station functional units (ALU, load/store, branch). It grants the CDB to one requesting unit per cycle in round-robin order. It captures the granted unit's tagged result one cycle later and broadcasts it to all reservation stations and the register-status/ROB logic as a single registered CDB beat. Branch flush (`br`) drops all in-flight grants and results.

## Interface
- `N_REQ`, 4, number of functional units contending for the CDB (2..8)
- `TAG_W`, 8, tag/index width; tag value 0 is reserved as "no tag"
- `DATA_W`, 32, result width
- `clk`  input  1  single clock; all state changes on rising edge
- `rst`  input  1  asynchronous, active-low reset
- `br`  input  1  branch mispredict flush, sampled on rising edge
- `req`  input  N_REQ  bit i: unit i has a ready entry and wants the bus
- `in_valid`  input  N_REQ  bit i: unit i is driving a result this cycle
- `in_index`  input  N_REQ*TAG_W  per-unit result tag, unit i at [i*TAG_W +: TAG_W]
- `in_result`  input  N_REQ*DATA_W  per-unit result, unit i at [i*DATA_W +: DATA_W]
- `grnt`  output  N_REQ  one-hot (or zero) registered grant
- `cdb_valid`  output  1  broadcast beat valid
- `cdb_index`  output  TAG_W  broadcast tag; forced 0 whenever `cdb_valid`=0
- `cdb_result`  output  DATA_W  broadcast value; forced 0 whenever `cdb_valid`=0
- `proto_err`  output  1  sticky: a unit drove `in_valid` without an outstanding grant

## Operation
- Reset (`rst`=0, async): `grnt`=0, `cdb_valid`=0, `cdb_index`=0, `cdb_result`=0, `proto_err`=0, round-robin pointer `rr_ptr`=0, pending register cleared.
- Arbitration stage: each edge, if `br`=0, scan `req` starting at `rr_ptr` and wrapping modulo N_REQ; the first set bit i becomes `grnt` = one-hot(i) for exactly one cycle; `rr_ptr` <= (i+1) mod N_REQ. If no request, `grnt` <= 0 and `rr_ptr` is unchanged.
- A unit with `grnt` high samples it at the next edge and drives `in_valid`/`in_index`/`in_result` for the following cycle.
- Pending stage: on the edge where `grnt`=one-hot(i) is dropped/replaced, record `pend_valid`<=1, `pend_owner`<=i.
- Capture/broadcast stage: if `pend_valid` and `in_valid[pend_owner]`, then next edge `cdb_valid`<=1, `cdb_index`<=`in_index[pend_owner]`, `cdb_result`<=`in_result[pend_owner]`. If the owner does not assert `in_valid` (entry vanished), no broadcast; the slot is lost silently.
- A granted result with `in_index`=0 is not broadcast (`cdb_valid` stays 0).
- `in_valid[j]` asserted while not (`pend_valid` and `pend_owner`=j) sets `proto_err`; that data is ignored. `proto_err` clears only on reset.
- Flush: `br`=1 at an edge -> `grnt`<=0, `pend_valid`<=0, `cdb_valid`<=0, `cdb_index`<=0, `cdb_result`<=0; `rr_ptr`<=0. `req` is ignored on that edge. Results arriving the cycle after a flush are dropped and do not set `proto_err`.
- Simultaneous grant + capture + broadcast each cycle is allowed; steady state is one CDB beat per cycle.

## Timing
- `req[i]` high before edge E -> `grnt[i]` high in cycle E..E+1 -> unit drives result E+1..E+2 -> `cdb_valid` high E+2..E+3. Latency is 3 edges, throughput is 1 beat/cycle.
- `grnt` and `cdb_*` are purely registered; there is no combinational path from `req`/`in_*` to outputs.
- `cdb_valid` is a one-cycle pulse per result; back-to-back beats from different or the same unit are permitted.
- Reset asserted mid-stream clears all outputs immediately (asynchronous), and outputs stay at reset values until the first edge after release.

## Test plan
- Single requester: `req`=4'b0100 for one cycle, unit 2 returns index 8'h15, result 32'hDEADBEEF -> `grnt`=4'b0100 one cycle; 2 cycles later `cdb_valid`=1, `cdb_index`=8'h15, `cdb_result`=32'hDEADBEEF for exactly one cycle.
- Round-robin fairness: `req`=4'b1111 held 8 cycles -> `grnt` sequence 0001,0010,0100,1000,0001,... and 8 consecutive CDB beats in that owner order.
- Pointer wrap: `rr_ptr`=3 (after granting unit 2), `req`=4'b0011 -> grant unit 0, then unit 1.
- Flush mid-flight: grant unit 1, `br`=1 on the edge the unit returns data -> no CDB beat, `grnt`=0, next `req`=4'b1110 grants unit 1 (pointer reset to 0).
- Protocol error and no-show: unit 3 asserts `in_valid` with no grant -> `proto_err`=1 sticky, no beat. Granted unit 0 does not assert `in_valid` -> no beat, next grant proceeds normally.
- Async reset: assert `rst`=0 between edges while `cdb_valid`=1 -> all outputs 0 immediately.
